// File: rtl/err_metric_sweep.sv
// Error-metric sweep for a 4-bit approximate multiplier: walks every nonzero
// operand pair and accumulates error count, distance, maximum and scaled relative error.
module err_metric_sweep #(
  parameter int SETTLE    = 1,
  parameter int RED_SCALE = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  input  logic [7:0]  prod,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count,
  output logic [15:0] err_dist,
  output logic [15:0] max_err,
  output logic [31:0] red_sum
);
  // 255 * 10000 needs 22 bits, so the divider retires 22 quotient bits
  localparam int DW = 22;

  typedef enum logic [2:0] {IDLE, DRIVE, CMP, DIV, ACC, FIN} state_t;

  state_t          r_state;
  logic [3:0]      r_settle;
  logic [4:0]      r_bit;
  logic [7:0]      r_diff;
  logic [7:0]      r_exact;
  logic [7:0]      r_rem;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_quo;

  logic [7:0]      w_exact;
  logic [7:0]      w_diff;
  logic [DW-1:0]   w_dvd;
  logic            w_last;
  logic [3:0]      w_nxt_a;
  logic [3:0]      w_nxt_b;
  logic [8:0]      w_rem_sh;
  logic            w_ge;
  logic [8:0]      w_rem_nx;

  assign w_exact  = {4'b0, op_a} * {4'b0, op_b};
  assign w_diff   = (prod >= w_exact) ? (prod - w_exact) : (w_exact - prod);
  assign w_dvd    = DW'(w_diff) * DW'(RED_SCALE);
  assign w_last   = (op_a == 4'd15) && (op_b == 4'd15);
  assign w_nxt_a  = (op_b == 4'd15) ? op_a + 4'd1 : op_a;
  assign w_nxt_b  = (op_b == 4'd15) ? 4'd1 : op_b + 4'd1;

  // Remainder stays below the divisor (<= 225), so 8 bits hold it between steps
  assign w_rem_sh = {r_rem, r_dvd[DW-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_exact};
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_exact}) : w_rem_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_settle  <= '0;
      r_bit     <= '0;
      r_diff    <= '0;
      r_exact   <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_quo     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      err_dist  <= '0;
      max_err   <= '0;
      red_sum   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          op_a <= '0;
          op_b <= '0;
          busy <= 1'b0;
          if (start) begin
            err_count <= '0;
            err_dist  <= '0;
            max_err   <= '0;
            red_sum   <= '0;
            op_a      <= 4'd1;
            op_b      <= 4'd1;
            busy      <= 1'b1;
            r_settle  <= '0;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_settle == 4'(SETTLE - 1)) r_state <= CMP;
          else r_settle <= r_settle + 4'd1;
        end
        CMP: begin
          r_diff  <= w_diff;
          r_exact <= w_exact;
          r_dvd   <= w_dvd;
          r_rem   <= '0;
          r_quo   <= '0;
          r_bit   <= '0;
          if (w_diff != 8'd0) begin
            r_state <= DIV;
          end else if (w_last) begin
            op_a    <= '0;
            op_b    <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= FIN;
          end else begin
            op_a     <= w_nxt_a;
            op_b     <= w_nxt_b;
            r_settle <= '0;
            r_state  <= DRIVE;
          end
        end
        DIV: begin
          r_rem <= w_rem_nx[7:0];
          r_quo <= {r_quo[DW-2:0], w_ge};
          r_dvd <= {r_dvd[DW-2:0], 1'b0};
          if (r_bit == 5'(DW - 1)) r_state <= ACC;
          else r_bit <= r_bit + 5'd1;
        end
        ACC: begin
          err_count <= err_count + 8'd1;
          err_dist  <= err_dist + 16'(r_diff);
          if (16'(r_diff) > max_err) max_err <= 16'(r_diff);
          red_sum   <= red_sum + 32'(r_quo);
          if (w_last) begin
            op_a    <= '0;
            op_b    <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= FIN;
          end else begin
            op_a     <= w_nxt_a;
            op_b     <= w_nxt_b;
            r_settle <= '0;
            r_state  <= DRIVE;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_err_metric_sweep.sv
// Directed bench: behavioural approximate-multiplier models with hand-computed metrics.
module tb_err_metric_sweep;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op_a, op_b;
  logic [7:0]  prod;
  logic        busy, done;
  logic [7:0]  err_count;
  logic [15:0] err_dist, max_err;
  logic [31:0] red_sum;
  int          mode;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ref3;

  err_metric_sweep #(.SETTLE(1), .RED_SCALE(10000)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .prod(prod),
    .busy(busy), .done(done), .err_count(err_count), .err_dist(err_dist),
    .max_err(max_err), .red_sum(red_sum)
  );

  always #5 clk = ~clk;

  // 0: exact, 1: (15,15)->209, 2: (3,5)->17 and (2,2)->3, 3: a*b-1 everywhere
  always_comb begin
    logic [7:0] ex;
    ex   = {4'b0, op_a} * {4'b0, op_b};
    prod = ex;
    case (mode)
      1: if (op_a == 4'd15 && op_b == 4'd15) prod = 8'd209;
      2: begin
        if (op_a == 4'd3 && op_b == 4'd5) prod = 8'd17;
        else if (op_a == 4'd2 && op_b == 4'd2) prod = 8'd3;
      end
      3: prod = ex - 8'd1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_metrics(input string tag, input int c, input int d, input int m, input int r);
    chk({tag, " err_count"}, 32'(err_count), c);
    chk({tag, " err_dist"},  32'(err_dist),  d);
    chk({tag, " max_err"},   32'(max_err),   m);
    chk({tag, " red_sum"},   red_sum,        r);
  endtask

  // Pulses start, then counts negedges until done is seen (bounded).
  task automatic sweep(input string tag, input int exp_lat, input int pulse_at);
    int cnt;
    bit got;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy@start"}, 32'(busy), 1);
    chk({tag, " op_a@start"}, 32'(op_a), 1);
    chk({tag, " op_b@start"}, 32'(op_b), 1);
    chk({tag, " cleared cnt"}, 32'(err_count), 0);
    chk({tag, " cleared red"}, red_sum, 0);
    cnt = 0;
    got = 1'b0;
    while (cnt < 20000 && !got) begin
      cnt++;
      if (done) got = 1'b1;
      else begin
        start = (cnt == pulse_at);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, " done latency"}, got ? 32'(cnt) : 32'd0, exp_lat);
    chk({tag, " busy@done"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, " done one-shot"}, 32'(done), 0);
    chk({tag, " op_a idle"}, 32'(op_a), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    ref3  = 0;
    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++)
        ref3 += 10000 / (a * b);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset op_a", 32'(op_a), 0);
    chk("reset op_b", 32'(op_b), 0);
    chk_metrics("reset", 0, 0, 0, 0);

    mode = 0;
    sweep("exact", 451, 0);
    chk_metrics("exact", 0, 0, 0, 0);

    mode = 1;
    sweep("m1515", 474, 0);
    chk_metrics("m1515", 1, 16, 16, 711);

    mode = 2;
    sweep("m2pair", 497, 300);
    chk_metrics("m2pair", 2, 3, 2, 3833);
    repeat (3) @(negedge clk);
    chk_metrics("hold", 2, 3, 2, 3833);

    mode = 0;
    sweep("restart", 451, 0);
    chk_metrics("restart", 0, 0, 0, 0);

    mode = 3;
    sweep("minus1", 5626, 0);
    chk_metrics("minus1", 225, 225, 1, ref3);

    // Reset during DIV of the 100th pair, with start asserted alongside
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2484) @(negedge clk);
    chk("mid busy", 32'(busy), 1);
    chk("mid op_a", 32'(op_a), 7);
    chk("mid op_b", 32'(op_b), 10);
    chk("mid cnt", 32'(err_count), 99);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst op_a", 32'(op_a), 0);
    chk("rst op_b", 32'(op_b), 0);
    chk_metrics("rst", 0, 0, 0, 0);
    @(negedge clk);
    chk("rst stays idle", 32'(busy), 0);

    sweep("after rst", 5626, 0);
    chk_metrics("after rst", 225, 225, 1, ref3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/err_metric_sweep.md
ERR_METRIC_SWEEP -- requirements
Module: err_metric_sweep

Interface
REQ-001 SHALL have parameter: SETTLE, 1, cycles op_a/op_b are held before prod is sampled (legal 1..15).
REQ-002 SHALL have parameter: RED_SCALE, 10000, fixed-point scale of the relative-error term.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  one-cycle request to run a full operand sweep.
REQ-006 SHALL have port: op_a  output  4  multiplicand driven to the 4-bit approximate multiplier under test.
REQ-007 SHALL have port: op_b  output  4  multiplier operand driven to the multiplier under test.
REQ-008 SHALL have port: prod  input  8  approximate product returned combinationally by the multiplier under test.
REQ-009 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when the sweep completes.
REQ-011 SHALL have port: err_count  output  8  number of pairs with prod != a*b.
REQ-012 SHALL have port: err_dist  output  16  sum of |prod - a*b| over all pairs.
REQ-013 SHALL have port: max_err  output  16  largest |prod - a*b| seen.
REQ-014 SHALL have port: red_sum  output  32  sum of floor(|prod - a*b| * RED_SCALE / (a*b)) over erroneous pairs.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, CMP, DIV, ACC, FIN.
REQ-016 SHALL sweep op_a outer 1..15 and op_b inner 1..15, 225 pairs; zero operands are never driven during a sweep.
REQ-017 SHALL, in IDLE, drive op_a = op_b = 0, busy = 0, and hold all metric outputs at their last values.
REQ-018 SHALL, when start = 1 in IDLE: clear all four metrics, load op_a = op_b = 1, and enter DRIVE with busy = 1 on the next cycle.
REQ-019 SHALL ignore start while busy = 1.
REQ-020 SHALL stay in DRIVE exactly SETTLE cycles with op_a/op_b stable, then enter CMP.
REQ-021 SHALL, in CMP (1 cycle), register prod, compute exact = op_a*op_b (8 bits), diff = |prod - exact| (unsigned, either sign of error).
REQ-022 SHALL, in CMP, advance to the next pair (DRIVE) or FIN when diff = 0; otherwise enter DIV.
REQ-023 SHALL, in DIV, compute floor(diff*RED_SCALE/exact) with a 22-iteration restoring divider, one quotient bit per cycle, exactly 22 cycles.
REQ-024 SHALL, in ACC (1 cycle): err_count += 1, err_dist += diff, max_err = max(max_err, diff), red_sum += quotient; then advance to the next pair or FIN.
REQ-025 SHALL give per-pair cost SETTLE+1 cycles when exact, SETTLE+24 cycles when erroneous.
REQ-026 SHALL, in FIN (1 cycle), assert done = 1, busy = 0, and return to IDLE; done is 0 in all other cycles.
REQ-027 SHALL update metric outputs only in ACC; no accumulator can overflow over 225 pairs with 4-bit operands and an 8-bit prod, so no saturation is applied.
REQ-028 SHALL treat max_err tie (diff equal to current max) as no change.

Reset
REQ-029 SHALL, on rst = 1 at a clock edge, from any state (including mid-DIV), enter IDLE with busy = 0, done = 0, op_a = op_b = 0, and all metrics = 0.
REQ-030 SHALL give rst priority over start in the same cycle.

Verification
REQ-031 SHALL cover: exact model prod = a*b, SETTLE = 1, start at edge k -> done pulses at edge k+451; metrics all 0.
REQ-032 SHALL cover: model exact except (15,15) -> 209 -> err_count 1, err_dist 16, max_err 16, red_sum 711.
REQ-033 SHALL cover: model exact except (3,5) -> 17 and (2,2) -> 3 -> err_count 2, err_dist 3, max_err 2, red_sum 1333+2500 = 3833.
REQ-034 SHALL cover: model prod = a*b - 1 for all pairs -> err_count 225, err_dist 225, max_err 1; red_sum equals bench reference model sum.
REQ-035 SHALL cover: rst asserted during DIV of pair 100 -> next cycle busy 0, op_a = op_b = 0, metrics 0; a following start runs a full clean sweep.
REQ-036 SHALL cover: start pulsed while busy -> no effect on the sweep; start after done -> metrics clear to 0 on the next cycle.
